// File: rtl/oam_dma.sv
// Sprite DMA controller: copies one 256-byte CPU page into PPU OAM and stalls the CPU meanwhile.
// Optional odd-cycle alignment wait is enabled by defining OAM_DMA_ODD_ALIGN_EN.
module oam_dma #(
  parameter logic [15:0] DMA_PORT     = 16'h4014,
  parameter logic [15:0] OAMADDR_PORT = 16'h2003
) (
  input  logic        clock25,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_o,
  input  logic        cpu_w,
  output logic        stall,
  output logic [15:0] dma_a,
  output logic        dma_r,
  input  logic [7:0]  dma_i,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_o,
  output logic        oam_w
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_page;
  logic [7:0]  r_base;
  logic [7:0]  r_idx;
  logic        r_stall;

  state_t      w_state_nx;
  logic [7:0]  w_page_nx;
  logic [7:0]  w_base_nx;
  logic [7:0]  w_idx_nx;
  logic        w_stall_nx;
  logic [7:0]  w_oam_addr;

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic        r_parity;

  always_ff @(posedge clock25) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (ce) begin
      r_parity <= ~r_parity;
    end
  end
`endif

  always_comb begin
    w_state_nx = r_state;
    w_page_nx  = r_page;
    w_base_nx  = r_base;
    w_idx_nx   = r_idx;
    w_stall_nx = r_stall;
    if (ce) begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_w && (cpu_a == OAMADDR_PORT)) begin
            w_base_nx = cpu_o;
          end
          if (cpu_w && (cpu_a == DMA_PORT)) begin
            w_page_nx  = cpu_o;
            w_idx_nx   = '0;
            w_state_nx = ST_ALIGN;
            w_stall_nx = 1'b1;
          end
        end
        ST_ALIGN: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
          // An odd parity here costs one extra ALIGN tick; parity is even on the next one.
          if (!r_parity) begin
            w_state_nx = ST_READ;
          end
`else
          w_state_nx = ST_READ;
`endif
        end
        ST_READ: begin
          w_state_nx = ST_WRITE;
        end
        ST_WRITE: begin
          if (r_idx == 8'hFF) begin
            w_state_nx = ST_IDLE;
            w_stall_nx = 1'b0;
          end else begin
            w_idx_nx   = r_idx + 8'd1;
            w_state_nx = ST_READ;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_stall_nx = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock25) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_page  <= '0;
      r_base  <= '0;
      r_idx   <= '0;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_page  <= w_page_nx;
      r_base  <= w_base_nx;
      r_idx   <= w_idx_nx;
      r_stall <= w_stall_nx;
    end
  end

  assign w_oam_addr = r_base + r_idx;

  assign stall = r_stall;
  assign dma_r = (r_state == ST_READ);
  assign dma_a = (r_state == ST_READ) ? {r_page, r_idx} : '0;
  assign oam_a = (r_state == ST_WRITE) ? w_oam_addr : '0;
  assign oam_o = (r_state == ST_WRITE) ? dma_i : '0;
  // Gated by reset so an aborted transfer never lands one more byte in OAM.
  assign oam_w = (r_state == ST_WRITE) && ce && !reset;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: PRG/OAM memories around the DUT and a page-copy reference model.
// Expected transfer length follows OAM_DMA_ODD_ALIGN_EN when the bench is built with it.
module tb_oam_dma;

  localparam logic [15:0] DMA_PORT     = 16'h4014;
  localparam logic [15:0] OAMADDR_PORT = 16'h2003;
`ifdef OAM_DMA_ODD_ALIGN_EN
  localparam int unsigned ALIGN_EN = 1;
`else
  localparam int unsigned ALIGN_EN = 0;
`endif

  logic        clock25 = 1'b0;
  logic        reset;
  logic        ce;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_o;
  logic        cpu_w;
  logic        stall;
  logic [15:0] dma_a;
  logic        dma_r;
  logic [7:0]  dma_i;
  logic [7:0]  oam_a;
  logic [7:0]  oam_o;
  logic        oam_w;

  always #5 clock25 = ~clock25;

  oam_dma #(
    .DMA_PORT(DMA_PORT),
    .OAMADDR_PORT(OAMADDR_PORT)
  ) dut (
    .clock25(clock25),
    .reset(reset),
    .ce(ce),
    .cpu_a(cpu_a),
    .cpu_o(cpu_o),
    .cpu_w(cpu_w),
    .stall(stall),
    .dma_a(dma_a),
    .dma_r(dma_r),
    .dma_i(dma_i),
    .oam_a(oam_a),
    .oam_o(oam_o),
    .oam_w(oam_w)
  );

  // Surrounding system: PRG memory with one-tick read latency, OAM write port, event counters.
  logic [7:0]  prg [65536];
  logic [7:0]  oam [256];
  logic [7:0]  oam_ref [256];
  logic [7:0]  rd_q = 8'h00;
  int unsigned stall_ticks = 0;
  int unsigned wr_pulses = 0;
  int unsigned ce_ticks = 0;

  assign dma_i = rd_q;

  always @(posedge clock25) begin
    if (ce && dma_r) rd_q <= prg[dma_a];
    if (oam_w) begin
      oam[oam_a] <= oam_o;
      wr_pulses  <= wr_pulses + 1;
    end
    if (ce && stall) stall_ticks <= stall_ticks + 1;
    if (reset) ce_ticks <= 0;
    else if (ce) ce_ticks <= ce_ticks + 1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a transfer of n bytes puts page byte i at OAM slot (base + i) mod 256.
  task automatic model_dma(input logic [7:0] page, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++)
      oam_ref[8'((int'(base) + i) % 256)] = prg[16'(int'(page) * 256 + i)];
  endtask

  // Stalled ticks: 1 ALIGN + 256 READ + 256 WRITE, plus one when the ALIGN tick sees odd parity.
  function automatic int unsigned exp_len(input int unsigned ticks_before_align);
    return 513 + ALIGN_EN * (ticks_before_align % 2);
  endfunction

  task automatic chk_oam(input string tag);
    int unsigned bad = 0;
    for (int i = 0; i < 256; i++)
      if (oam[i] !== oam_ref[i]) bad++;
    chk(tag, bad, 32'd0);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock25);
    ce = 1'b1; cpu_w = 1'b1; cpu_a = a; cpu_o = d;
    @(negedge clock25);
    ce = 1'b0; cpu_w = 1'b0;
  endtask

  task automatic run_dma(input string tag, input logic [7:0] page, input bit rnd_ce,
                         input int duty, input bit noise);
    int unsigned st0, wr0, t0, frozen_bad;
    logic [33:0] prev, cur;
    bit prev_ce, done;
    @(negedge clock25);
    ce = 1'b1; cpu_w = 1'b1; cpu_a = DMA_PORT; cpu_o = page;
    @(negedge clock25);
    ce = 1'b0; cpu_w = 1'b0;
    st0 = stall_ticks; wr0 = wr_pulses; t0 = ce_ticks;
    chk({tag, "_stall_rise"}, 32'(stall), 32'd1);
    done = 1'b0; frozen_bad = 0; prev_ce = 1'b1; prev = '0;
    for (int n = 0; n < 8000; n++) begin
      if (stall !== 1'b1) begin
        done = 1'b1;
        break;
      end
      ce    = rnd_ce ? ($urandom_range(2) == 0) : ((n % duty) == 0);
      cpu_w = noise && ($urandom_range(1) == 1);
      cpu_a = ($urandom_range(1) == 1) ? DMA_PORT : OAMADDR_PORT;
      cpu_o = 8'($urandom);
      #1;
      cur = {dma_a, dma_r, oam_a, oam_o, stall};
      if (!prev_ce && cur !== prev) frozen_bad++;
      if (oam_w && !ce) frozen_bad++;
      prev = cur; prev_ce = ce;
      @(negedge clock25);
    end
    ce = 1'b0; cpu_w = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_ticks"}, stall_ticks - st0, exp_len(t0));
    chk({tag, "_pulses"}, wr_pulses - wr0, 32'd256);
    chk({tag, "_frozen"}, frozen_bad, 32'd0);
  endtask

  initial begin
    logic [7:0] pg, bs;
    int unsigned wr0;
    bit hit;

    reset = 1'b1; ce = 1'b1; cpu_w = 1'b1; cpu_a = DMA_PORT; cpu_o = 8'h05;
    for (int i = 0; i < 65536; i++) prg[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) prg[16'(16'h0300 + i)] = 8'(i);
    repeat (3) @(negedge clock25);
    reset = 1'b0; cpu_w = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_dma_r", 32'(dma_r), 32'd0);
    chk("rst_dma_a", 32'(dma_a), 32'd0);
    chk("rst_oam_a", 32'(oam_a), 32'd0);
    chk("rst_oam_o", 32'(oam_o), 32'd0);
    chk("rst_oam_w", 32'(oam_w), 32'd0);
    @(negedge clock25);
    ce = 1'b0;

    // Byte copy: page $03 holds its own low address byte.
    cpu_write(OAMADDR_PORT, 8'h00);
    run_dma("copy", 8'h03, 1'b0, 1, 1'b0);
    model_dma(8'h03, 8'h00, 256);
    chk_oam("copy_oam");
    chk("copy_oam00", 32'(oam[0]), 32'h00);
    chk("copy_oamff", 32'(oam[255]), 32'hFF);

    // OAM offset wraps modulo 256.
    cpu_write(OAMADDR_PORT, 8'hF0);
    run_dma("wrap", 8'h03, 1'b0, 1, 1'b0);
    model_dma(8'h03, 8'hF0, 256);
    chk_oam("wrap_oam");
    chk("wrap_f0", 32'(oam[8'hF0]), 32'h00);
    chk("wrap_ff", 32'(oam[8'hFF]), 32'h0F);
    chk("wrap_00", 32'(oam[8'h00]), 32'h10);
    chk("wrap_ef", 32'(oam[8'hEF]), 32'hFF);

    // ce one clock in four.
    pg = 8'($urandom); bs = 8'($urandom);
    cpu_write(OAMADDR_PORT, bs);
    run_dma("gate4", pg, 1'b0, 4, 1'b0);
    model_dma(pg, bs, 256);
    chk_oam("gate4_oam");

    // Random pages, offsets, ce pattern and CPU writes to both ports during the transfer.
    for (int k = 0; k < 3; k++) begin
      pg = 8'($urandom); bs = 8'($urandom);
      cpu_write(OAMADDR_PORT, bs);
      run_dma("noise", pg, 1'b1, 1, 1'b1);
      model_dma(pg, bs, 256);
      chk_oam("noise_oam");
    end

    // Reset after 100 OAM writes, with port writes during reset that must be discarded.
    pg = 8'($urandom); bs = 8'($urandom);
    cpu_write(OAMADDR_PORT, bs);
    @(negedge clock25);
    ce = 1'b1; cpu_w = 1'b1; cpu_a = DMA_PORT; cpu_o = pg;
    @(negedge clock25);
    cpu_w = 1'b0;
    wr0 = wr_pulses; hit = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (wr_pulses - wr0 >= 100) begin
        hit = 1'b1;
        break;
      end
      @(negedge clock25);
    end
    chk("rst_mid_reached", 32'(hit), 32'd1);
    reset = 1'b1; cpu_w = 1'b1; cpu_a = DMA_PORT; cpu_o = 8'h77;
    @(negedge clock25);
    #1;
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_oam_w", 32'(oam_w), 32'd0);
    chk("rst_mid_dma_r", 32'(dma_r), 32'd0);
    cpu_a = OAMADDR_PORT; cpu_o = 8'h55;
    @(negedge clock25);
    reset = 1'b0; ce = 1'b0; cpu_w = 1'b0;
    @(negedge clock25);
    chk("rst_mid_stall_after", 32'(stall), 32'd0);
    chk("rst_mid_pulses", wr_pulses - wr0, 32'd100);
    model_dma(pg, bs, 100);
    chk_oam("rst_mid_oam");

    // Fresh transfer after reset: offset comes back as 0.
    pg = 8'($urandom);
    run_dma("post_rst", pg, 1'b1, 1, 1'b0);
    model_dma(pg, 8'h00, 256);
    chk_oam("post_rst_oam");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
